// File: rtl/count_chk_pkg.sv
// Shared types and constants for the count checker: FSM state encoding and
// the width/limit of the statistics counters.
package count_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } chk_state_e;

    localparam int          STAT_W   = 16;
    localparam logic [15:0] STAT_MAX = 16'hFFFF;

endpackage : count_chk_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter used for the checker statistics. Clear has priority
// over increment; the count sticks at all-ones instead of wrapping.
module sat_counter
    import count_chk_pkg::*;
#(
    parameter int W = STAT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = CNT_ZERO;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : sat_counter

// File: rtl/count_checker.sv
// Monitors a free-running up-counter. After SYNC_LEN consecutive correct
// increments the checker locks; while locked, any sequence break raises a
// one-cycle err pulse and drops back to SYNC. Legal all-ones -> 0 wraps and
// violations are tallied in saturating statistics counters.
module count_checker
    import count_chk_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int SYNC_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [WIDTH-1:0]  count,
    input  logic              clr,
    output logic              locked,
    output logic              err,
    output logic [STAT_W-1:0] err_cnt,
    output logic [STAT_W-1:0] wrap_cnt,
    output logic [WIDTH-1:0]  expected
);

    // Run length never needs to exceed SYNC_LEN (max 15).
    localparam int             RUN_W    = 4;
    localparam logic [RUN_W-1:0] RUN_TGT  = RUN_W'(SYNC_LEN);
    localparam logic [RUN_W-1:0] RUN_ZERO = {RUN_W{1'b0}};
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [WIDTH-1:0] VAL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] VAL_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] VAL_MAX  = {WIDTH{1'b1}};

    chk_state_e       state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             err_q, err_d;
    logic             locked_q, locked_d;
    logic [WIDTH-1:0] expected_q, expected_d;
    logic [WIDTH-1:0] prev_inc_s;
    logic             correct_s;
    logic             err_inc_s;
    logic             wrap_inc_s;

    assign prev_inc_s = prev_q + VAL_ONE;
    assign correct_s  = (count == prev_inc_s);

    // Next-state logic: sequence tracking, lock/unlock decisions and the
    // increment requests for the statistics counters.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        run_d      = run_q;
        err_d      = 1'b0;
        err_inc_s  = 1'b0;
        wrap_inc_s = 1'b0;
        if (en) begin
            prev_d = count;
            case (state_q)
                IDLE: begin
                    run_d   = RUN_ZERO;
                    state_d = SYNC;
                end
                SYNC: begin
                    if (correct_s) begin
                        run_d = run_q + RUN_ONE;
                        if ((run_q + RUN_ONE) >= RUN_TGT) begin
                            state_d = LOCK;
                        end else begin
                            state_d = SYNC;
                        end
                    end else begin
                        run_d = RUN_ZERO;
                    end
                end
                LOCK: begin
                    if (correct_s) begin
                        // A correct sample from all-ones can only be 0.
                        if (prev_q == VAL_MAX) begin
                            wrap_inc_s = 1'b1;
                        end else begin
                            wrap_inc_s = 1'b0;
                        end
                    end else begin
                        err_d     = 1'b1;
                        err_inc_s = 1'b1;
                        run_d     = RUN_ZERO;
                        state_d   = SYNC;
                    end
                end
                default: begin
                    run_d   = RUN_ZERO;
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output values registered alongside the state they describe.
    always_comb begin
        locked_d = (state_d == LOCK);
        if (state_d == IDLE) begin
            expected_d = VAL_ZERO;
        end else begin
            expected_d = prev_d + VAL_ONE;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prev_q     <= VAL_ZERO;
            run_q      <= RUN_ZERO;
            err_q      <= 1'b0;
            locked_q   <= 1'b0;
            expected_q <= VAL_ZERO;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            run_q      <= run_d;
            err_q      <= err_d;
            locked_q   <= locked_d;
            expected_q <= expected_d;
        end
    end

    sat_counter #(.W(STAT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_inc_s),
        .clr   (clr),
        .cnt   (err_cnt)
    );

    sat_counter #(.W(STAT_W)) u_wrap_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wrap_inc_s),
        .clr   (clr),
        .cnt   (wrap_cnt)
    );

    assign locked   = locked_q;
    assign err      = err_q;
    assign expected = expected_q;

endmodule : count_checker

// File: tb/tb_count_checker.sv
// Bench for count_checker: directed sequences, a behavioural reference model
// checked every cycle, and literal spot checks at the interesting points.
module tb_count_checker;

    localparam int WIDTH    = 5;
    localparam int SYNC_LEN = 4;
    localparam int MOD      = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [WIDTH-1:0]  count = '0;
    logic              clr = 1'b0;
    logic              locked;
    logic              err;
    logic [15:0]       err_cnt;
    logic [15:0]       wrap_cnt;
    logic [WIDTH-1:0]  expected;

    logic              s_inc = 1'b0;
    logic              s_clr = 1'b0;
    logic [15:0]       s_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    count_checker #(.WIDTH(WIDTH), .SYNC_LEN(SYNC_LEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .count    (count),
        .clr      (clr),
        .locked   (locked),
        .err      (err),
        .err_cnt  (err_cnt),
        .wrap_cnt (wrap_cnt),
        .expected (expected)
    );

    sat_counter #(.W(16)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (s_inc),
        .clr   (s_clr),
        .cnt   (s_cnt)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: started/locked flags, run length and last sample.
    bit m_active, m_locked, m_err;
    int m_run, m_prev, m_errs, m_wraps;
    logic m_ok;
    assign m_ok = (int'({27'd0, count}) == ((m_prev + 1) % MOD));

    // Model update on each clock using the spec's rules directly.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0; m_locked <= 1'b0; m_err <= 1'b0;
            m_run <= 0; m_prev <= 0; m_errs <= 0; m_wraps <= 0;
        end else begin
            m_err <= 1'b0;
            if (en) begin
                m_prev <= int'({27'd0, count});
                if (!m_active) begin
                    m_active <= 1'b1;
                    m_run    <= 0;
                end else if (!m_locked) begin
                    if (m_ok) begin
                        m_run <= m_run + 1;
                        if (m_run + 1 >= SYNC_LEN) m_locked <= 1'b1;
                    end else begin
                        m_run <= 0;
                    end
                end else begin
                    if (m_ok) begin
                        if (m_prev == MOD - 1) m_wraps <= (m_wraps < 65535) ? m_wraps + 1 : 65535;
                    end else begin
                        m_err    <= 1'b1;
                        m_errs   <= (m_errs < 65535) ? m_errs + 1 : 65535;
                        m_run    <= 0;
                        m_locked <= 1'b0;
                    end
                end
            end
            if (clr) begin
                m_errs  <= 0;
                m_wraps <= 0;
            end
        end
    end

    // Every-cycle comparison of DUT against the model, away from the active edge.
    always @(negedge clk) begin
        chk("locked",   32'(locked),   32'(m_locked));
        chk("err",      32'(err),      32'(m_err));
        chk("err_cnt",  32'(err_cnt),  32'(m_errs));
        chk("wrap_cnt", 32'(wrap_cnt), 32'(m_wraps));
        chk("expected", 32'(expected), m_active ? 32'((m_prev + 1) % MOD) : 32'd0);
    end

    // Apply one cycle of stimulus; returns at the following negedge.
    task automatic step(input logic e, input int c, input logic cl);
        en    = e;
        count = WIDTH'(c);
        clr   = cl;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_locked",   32'(locked),   32'd0);
        chk("rst_expected", 32'(expected), 32'd0);
        chk("rst_err_cnt",  32'(err_cnt),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean lock on 0..4
        for (int i = 0; i <= 3; i++) step(1'b1, i, 1'b0);
        chk("lock_not_yet", 32'(locked), 32'd0);
        step(1'b1, 4, 1'b0);
        chk("lock_locked",   32'(locked),   32'd1);
        chk("lock_expected", 32'(expected), 32'd5);

        // Wrap 30,31,0,1 while locked
        for (int i = 5; i <= 31; i++) step(1'b1, i, 1'b0);
        chk("wrap_before", 32'(wrap_cnt), 32'd0);
        step(1'b1, 0, 1'b0);
        chk("wrap_cnt", 32'(wrap_cnt), 32'd1);
        step(1'b1, 1, 1'b0);
        chk("wrap_locked", 32'(locked), 32'd1);
        chk("wrap_err",    32'(err),    32'd0);

        // Glitch 10,11,13 then relock on 14..17
        for (int i = 2; i <= 11; i++) step(1'b1, i, 1'b0);
        step(1'b1, 13, 1'b0);
        chk("glitch_err",      32'(err),      32'd1);
        chk("glitch_err_cnt",  32'(err_cnt),  32'd1);
        chk("glitch_locked",   32'(locked),   32'd0);
        chk("glitch_expected", 32'(expected), 32'd14);
        for (int i = 14; i <= 16; i++) step(1'b1, i, 1'b0);
        chk("glitch_err_gone", 32'(err),    32'd0);
        chk("relock_not_yet",  32'(locked), 32'd0);
        step(1'b1, 17, 1'b0);
        chk("relocked", 32'(locked), 32'd1);

        // Stall: locked at 7, en low 20 cycles, then 8
        for (int i = 18; i <= 31; i++) step(1'b1, i, 1'b0);
        for (int i = 0; i <= 7; i++) step(1'b1, i, 1'b0);
        chk("stall_wraps", 32'(wrap_cnt), 32'd2);
        for (int i = 0; i < 20; i++) step(1'b0, 3, 1'b0);
        chk("stall_hold_locked",   32'(locked),   32'd1);
        chk("stall_hold_expected", 32'(expected), 32'd8);
        step(1'b1, 8, 1'b0);
        chk("stall_err",     32'(err),     32'd0);
        chk("stall_locked",  32'(locked),  32'd1);
        chk("stall_err_cnt", 32'(err_cnt), 32'd1);

        // Stuck value while locked is a violation
        step(1'b1, 8, 1'b0);
        chk("stuck_err",     32'(err),     32'd1);
        chk("stuck_err_cnt", 32'(err_cnt), 32'd2);
        for (int i = 9; i <= 12; i++) step(1'b1, i, 1'b0);
        chk("stuck_relock", 32'(locked), 32'd1);

        // Clear coincident with an error: clear wins, err still pulses
        step(1'b1, 20, 1'b1);
        chk("clr_err",      32'(err),      32'd1);
        chk("clr_err_cnt",  32'(err_cnt),  32'd0);
        chk("clr_wrap_cnt", 32'(wrap_cnt), 32'd0);
        chk("clr_locked",   32'(locked),   32'd0);

        // Relock, then reset mid-lock
        for (int i = 21; i <= 24; i++) step(1'b1, i, 1'b0);
        chk("pre_rst_locked", 32'(locked), 32'd1);
        en = 1'b1; count = WIDTH'(25);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_locked",   32'(locked),   32'd0);
        chk("arst_expected", 32'(expected), 32'd0);
        chk("arst_err_cnt",  32'(err_cnt),  32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 9, 1'b0);
        chk("restart_locked",   32'(locked),   32'd0);
        chk("restart_expected", 32'(expected), 32'd10);
        for (int i = 10; i <= 13; i++) step(1'b1, i, 1'b0);
        chk("restart_relock", 32'(locked), 32'd1);
        step(1'b0, 0, 1'b0);

        // Saturation of the 16-bit statistics counter after 65535 increments
        s_inc = 1'b1;
        repeat (65535) @(posedge clk);
        @(negedge clk);
        s_inc = 1'b0;
        chk("sat_max", 32'(s_cnt), 32'h0000FFFF);
        s_inc = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sat_hold", 32'(s_cnt), 32'h0000FFFF);
        s_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_clr = 1'b0;
        chk("sat_clr_wins", 32'(s_cnt), 32'd0);
        @(posedge clk);
        @(negedge clk);
        s_inc = 1'b0;
        chk("sat_after_clr", 32'(s_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_count_checker

// File: doc/count_checker.md
COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, giving the monitored count width.
REQ-002 The block SHALL have parameter SYNC_LEN, default 4, giving the consecutive correct increments needed to lock (legal range 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port en, input, 1 bit: count is a valid sample this cycle.
REQ-006 The block SHALL have port count, input, WIDTH bits: the free-running up-counter value under observation.
REQ-007 The block SHALL have port clr, input, 1 bit: synchronous clear of the statistics counters.
REQ-008 The block SHALL have port locked, output, 1 bit: the checker is in LOCK.
REQ-009 The block SHALL have port err, output, 1 bit: one-cycle pulse on a sequence violation while locked.
REQ-010 The block SHALL have port err_cnt, output, 16 bits: saturating violation count.
REQ-011 The block SHALL have port wrap_cnt, output, 16 bits: saturating count of legal wraps from all-ones to 0.
REQ-012 The block SHALL have port expected, output, WIDTH bits: the value required on the next valid sample.

Function
REQ-013 The block SHALL implement FSM states IDLE, SYNC and LOCK.
REQ-014 The block SHALL define a sample as correct when count equals (prev + 1) mod 2^WIDTH, where prev is the last valid sample.
REQ-015 In IDLE, on the first en the block SHALL capture prev = count, clear run to 0, and go to SYNC.
REQ-016 In SYNC, a correct sample SHALL increment run, and run reaching SYNC_LEN SHALL move the FSM to LOCK.
REQ-017 In SYNC, an incorrect sample SHALL reset run to 0 with no err and no err_cnt change.
REQ-018 In LOCK, an incorrect sample (including a repeated/stuck value) SHALL pulse err, increment err_cnt, reset run to 0 and move to SYNC.
REQ-019 In LOCK, a correct sample with prev = all-ones and count = 0 SHALL increment wrap_cnt.
REQ-020 On every valid sample, in all states, prev SHALL be updated to count.
REQ-021 While en = 0, state, prev, run and all counters SHALL hold.
REQ-022 Outputs SHALL be registered: err and the counter updates SHALL appear in the cycle after the sampling edge.
REQ-023 locked SHALL assert in the cycle after the locking sample.
REQ-024 expected SHALL equal prev + 1 (mod 2^WIDTH) and SHALL be 0 in IDLE.
REQ-025 err_cnt and wrap_cnt SHALL saturate at 16'hFFFF without wrapping.
REQ-026 clr SHALL zero err_cnt and wrap_cnt and SHALL win over a same-cycle increment; err SHALL still pulse and the FSM SHALL be unaffected.

Reset
REQ-027 While rst_n = 0, the block SHALL hold state = IDLE, prev = 0, run = 0, locked = 0, err = 0, err_cnt = 0, wrap_cnt = 0 and expected = 0.
REQ-028 Reset mid-operation SHALL abort immediately, and the sequence SHALL restart from IDLE on the first en after release.

Structure
REQ-029 Package count_chk_pkg SHALL hold the state enum (IDLE/SYNC/LOCK) and the constants STAT_W = 16 and STAT_MAX = 16'hFFFF.
REQ-030 The block SHALL contain one sub-module, sat_counter (STAT_W-bit saturating counter with inc and clr), instantiated twice: once for err_cnt and once for wrap_cnt.

Verification
REQ-031 The bench SHALL cover clean lock: en = 1, count 0,1,2,3,4 -> locked = 1 the cycle after count = 4, err never asserted, expected = 5.
REQ-032 The bench SHALL cover wrap: locked, count 30,31,0,1 -> wrap_cnt = 1, err = 0, locked stays 1.
REQ-033 The bench SHALL cover a glitch while locked: count 10,11,13 -> one err pulse, err_cnt = 1, locked = 0; then 14,15,16,17 -> relocked.
REQ-034 The bench SHALL cover a stall: locked at 7, en low for 20 cycles, then count 8 -> no err, locked stays 1.
REQ-035 The bench SHALL cover clear plus saturation: force 65535 errors -> err_cnt = 16'hFFFF; clr coincident with a further error -> err_cnt = 0 and err pulses.
REQ-036 The bench SHALL cover reset mid-lock: rst_n low 1 cycle while locked -> all outputs 0 asynchronously, state = IDLE; next en restarts SYNC.
